// File: rtl/issue_scoreboard_if.sv
// Decode/issue/writeback handshake bundle for the issue scoreboard.
// The master side is the pipeline (decoder, execute, writeback); the slave side is the scoreboard.
interface issue_scoreboard_if;
    logic        id_valid;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  id_rd_addr;
    logic        id_wb_en;
    logic        id_ready;
    logic        ex_ready;
    logic        issue_fire;
    logic        wb_release;
    logic [4:0]  wb_rd_addr;
    logic [3:0]  inflight;
    logic [31:0] stall_cycles;
    logic        sb_err;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
        output id_rd_addr, id_wb_en, ex_ready, wb_release, wb_rd_addr,
        input  id_ready, issue_fire, inflight, stall_cycles, sb_err
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
        input  id_rd_addr, id_wb_en, ex_ready, wb_release, wb_rd_addr,
        output id_ready, issue_fire, inflight, stall_cycles, sb_err
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue-stage register scoreboard: stalls decode on RAW/WAW/in-flight-limit hazards and
// releases registers as writebacks retire. Hazards look only at registered counts.
module issue_scoreboard #(
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input logic               clk,
    input logic               rst_n,
    issue_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] PendMax     = {CNT_W{1'b1}};
    localparam logic [3:0]       InflightMax = 4'(MAX_INFLIGHT);

    // Entry 0 is never written, so x0 always reads as not pending.
    logic [CNT_W-1:0] pend_q [32];
    logic [CNT_W-1:0] pend_d [32];
    logic [3:0]       inflight_q, inflight_d;
    logic [31:0]      stall_q, stall_d;
    logic             err_q, err_d;

    logic raw_hazard, waw_hazard, limit_hazard, ready, fire;
    logic inc, rel, rel_bad, rel_ok;

    always_comb begin
        raw_hazard = (sb.id_uses_rs1 && sb.id_rs1_addr != 5'd0 && pend_q[sb.id_rs1_addr] != '0) ||
                     (sb.id_uses_rs2 && sb.id_rs2_addr != 5'd0 && pend_q[sb.id_rs2_addr] != '0);
        waw_hazard   = sb.id_wb_en && sb.id_rd_addr != 5'd0 && pend_q[sb.id_rd_addr] == PendMax;
        limit_hazard = sb.id_wb_en && inflight_q == InflightMax;
        ready        = sb.ex_ready && !(raw_hazard || waw_hazard || limit_hazard);
        fire         = sb.id_valid && ready;
        inc          = fire && sb.id_wb_en && sb.id_rd_addr != 5'd0;
        rel          = sb.wb_release && sb.wb_rd_addr != 5'd0;
        rel_bad      = rel && (pend_q[sb.wb_rd_addr] == '0 || inflight_q == 4'd0);
        rel_ok       = rel && !rel_bad;
    end

    always_comb begin
        pend_d = pend_q;
        if (inc) begin
            pend_d[sb.id_rd_addr] = pend_q[sb.id_rd_addr] + CNT_W'(1);
        end
        // Applied on top of the increment so an issue and release of the same rd cancel out.
        if (rel_ok) begin
            pend_d[sb.wb_rd_addr] = pend_d[sb.wb_rd_addr] - CNT_W'(1);
        end
        pend_d[0] = '0;

        unique case ({inc, rel_ok})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = inflight_q - 4'd1;
            default: inflight_d = inflight_q;
        endcase

        stall_d = (sb.id_valid && !ready) ? stall_q + 32'd1 : stall_q;
        err_d   = err_q || rel_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                pend_q[i] <= '0;
            end
            inflight_q <= 4'd0;
            stall_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            inflight_q <= inflight_d;
            stall_q    <= stall_d;
            err_q      <= err_d;
        end
    end

    assign sb.id_ready     = ready;
    assign sb.issue_fire   = fire;
    assign sb.inflight     = inflight_q;
    assign sb.stall_cycles = stall_q;
    assign sb.sb_err       = err_q;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed hazard scenarios plus random traffic,
// with expected responses queued by the driver and checked by an independent monitor.
module tb_issue_scoreboard;
    logic clk;
    logic rst_n;

    issue_scoreboard_if sb_if ();

    issue_scoreboard #(
        .CNT_W        (2),
        .MAX_INFLIGHT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready;
        logic        fire;
        logic [3:0]  inflight;
        logic [31:0] stall;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain integer counts per architectural register.
    int          pend_m [32];
    int          inflight_m;
    logic [31:0] stall_m;
    logic        err_m;

    localparam int PendLimit     = 3;
    localparam int InflightLimit = 4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("id_ready",     32'(sb_if.id_ready),   32'(mon_e.ready));
            chk("issue_fire",   32'(sb_if.issue_fire), 32'(mon_e.fire));
            chk("inflight",     32'(sb_if.inflight),   32'(mon_e.inflight));
            chk("stall_cycles", sb_if.stall_cycles,    mon_e.stall);
            chk("sb_err",       32'(sb_if.sb_err),     32'(mon_e.err));
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 32; i++) pend_m[i] = 0;
        inflight_m = 0;
        stall_m    = 32'd0;
        err_m      = 1'b0;
    endtask

    // Applies one cycle of inputs, queues the expected response, then advances the model.
    task automatic drive(input logic v, input int rs1, input logic u1, input int rs2,
                         input logic u2, input int rd, input logic wb, input logic exr,
                         input logic rel, input int wbrd);
        bit   stall_reason;
        logic rdy;
        logic fr;
        exp_t e;
        sb_if.id_valid    = v;
        sb_if.id_rs1_addr = 5'(rs1);
        sb_if.id_uses_rs1 = u1;
        sb_if.id_rs2_addr = 5'(rs2);
        sb_if.id_uses_rs2 = u2;
        sb_if.id_rd_addr  = 5'(rd);
        sb_if.id_wb_en    = wb;
        sb_if.ex_ready    = exr;
        sb_if.wb_release  = rel;
        sb_if.wb_rd_addr  = 5'(wbrd);

        stall_reason = (u1 && rs1 != 0 && pend_m[rs1] > 0) ||
                       (u2 && rs2 != 0 && pend_m[rs2] > 0) ||
                       (wb && rd != 0 && pend_m[rd] == PendLimit) ||
                       (wb && inflight_m == InflightLimit);
        rdy = exr && !stall_reason;
        fr  = v && rdy;
        e.ready    = rdy;
        e.fire     = fr;
        e.inflight = 4'(inflight_m);
        e.stall    = stall_m;
        e.err      = err_m;
        exp_q.push_back(e);

        @(posedge clk);
        if (rst_n) begin
            if (rel && wbrd != 0) begin
                if (pend_m[wbrd] == 0 || inflight_m == 0) begin
                    err_m = 1'b1;
                end else begin
                    pend_m[wbrd]--;
                    inflight_m--;
                end
            end
            if (fr && wb && rd != 0) begin
                pend_m[rd]++;
                inflight_m++;
            end
            if (v && !rdy) stall_m = stall_m + 32'd1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    // Called #1 after a rising edge; asserts reset between edges.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        drive(1, 1, 1, 2, 1, 3, 1, 1, 0, 0);
        drive(1, 1, 1, 2, 1, 3, 1, 0, 1, 4);
        rst_n = 1'b1;
    endtask

    task automatic rand_cycle();
        int cands[$];
        int wbrd;
        logic rel;
        for (int i = 1; i < 32; i++) if (pend_m[i] > 0) cands.push_back(i);
        rel = ($urandom % 10) < 4;
        if (cands.size() > 0 && ($urandom % 8) != 0)
            wbrd = cands[$urandom % cands.size()];
        else
            wbrd = $urandom % 8;
        drive(($urandom % 4) != 0, $urandom % 8, $urandom % 2 == 1, $urandom % 8,
              $urandom % 2 == 1, $urandom % 8, $urandom % 3 != 0, ($urandom % 5) != 0,
              rel, wbrd);
    endtask

    initial begin
        rst_n = 1'b0;
        sb_if.id_valid = 1'b0;  sb_if.id_rs1_addr = '0; sb_if.id_rs2_addr = '0;
        sb_if.id_uses_rs1 = 1'b0; sb_if.id_uses_rs2 = 1'b0; sb_if.id_rd_addr = '0;
        sb_if.id_wb_en = 1'b0;  sb_if.ex_ready = 1'b0; sb_if.wb_release = 1'b0;
        sb_if.wb_rd_addr = '0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // RAW on x5, released while the reader stalls; reader goes the cycle after.
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 5, 1, 0, 0, 6, 1, 1, 0, 0);
        drive(1, 5, 1, 0, 0, 6, 1, 1, 1, 5);
        drive(1, 5, 1, 0, 0, 6, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 6);

        // x0 is never a hazard and writes to it are not counted.
        drive(1, 0, 1, 0, 1, 0, 1, 1, 0, 0);
        drive(1, 0, 1, 0, 1, 0, 1, 1, 0, 0);

        // In-flight limit.
        for (int r = 1; r <= 4; r++) drive(1, 0, 0, 0, 0, r, 1, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 10, 1, 1, 0, 0);
        drive(1, 8, 1, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 10, 1, 1, 1, 1);
        drive(1, 0, 0, 0, 0, 10, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 4);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 10);

        // Per-register saturation on x11 (WAW at max count).
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 11, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 11);

        // Same-cycle issue and release of x7.
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 7, 1, 1, 1, 7);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 7);
        idle(1);

        // Spurious release of x9 sets the sticky error.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 9);
        idle(2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        for (int n = 0; n < 300; n++) rand_cycle();
        do_reset();
        for (int n = 0; n < 300; n++) rand_cycle();

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
